// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the 800x600@72 raster generator: visible area,
// porches, sync widths, totals, default sync polarity, the colour-bar
// palette used by the optional test pattern (VGA_TEST_PATTERN_EN), and
// small helpers for bar selection.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned CNT_W         = 12;

  localparam int unsigned DISP_COLS_DEF = 800;
  localparam int unsigned H_FP_DEF      = 56;
  localparam int unsigned H_SYNC_DEF    = 120;
  localparam int unsigned H_BP_DEF      = 64;
  localparam int unsigned H_TOTAL_DEF   = DISP_COLS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned DISP_ROWS_DEF = 600;
  localparam int unsigned V_FP_DEF      = 37;
  localparam int unsigned V_SYNC_DEF    = 6;
  localparam int unsigned V_BP_DEF      = 23;
  localparam int unsigned V_TOTAL_DEF   = DISP_ROWS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic        SYNC_POL_DEF  = 1'b1;

  localparam int unsigned NUM_BARS      = 8;

  // Raw per-pixel timing flags; vis is the MSB of the packed form.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } sync_bits_t;

  // Colour-bar palette, left to right.
  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'hFF;
      3'd1:    c = 8'hE0;
      3'd2:    c = 8'hFC;
      3'd3:    c = 8'h1C;
      3'd4:    c = 8'h1F;
      3'd5:    c = 8'h03;
      3'd6:    c = 8'hE3;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Bar index of a column using compares against bar boundaries (no divider).
  // Columns past the last boundary saturate at the last bar; they are blanked anyway.
  function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] col,
                                           input int unsigned      bar_w);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 1; i < NUM_BARS; i++) begin
      if (32'(col) >= i * bar_w) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle between the timing generator and the draw stage / DAC pins.
//   col_counter, row_counter : raster position (to draw stage)
//   rgb_in                   : pixel from draw stage
//   test_pattern             : colour-bar select (used only with VGA_TEST_PATTERN_EN)
//   rgb, hsync, vsync        : to DAC pins
//   video_on, frame_tick     : visible-area flag, once-per-frame pulse
// master = the timing generator, slave = the draw stage / consumer side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic [11:0] col_counter;
  logic [11:0] row_counter;
  logic [7:0]  rgb_in;
  logic        test_pattern;
  logic [7:0]  rgb;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_tick;

  modport master (
    output col_counter, row_counter, rgb, hsync, vsync, video_on, frame_tick,
    input  rgb_in, test_pattern
  );

  modport slave (
    input  col_counter, row_counter, rgb, hsync, vsync, video_on, frame_tick,
    output rgb_in, test_pattern
  );
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// ---------------------------------------------------------------------------
// sync_delay_line
// DEPTH-stage (0..4) shift register of WIDTH bits with an asynchronous
// active-low reset to a caller-supplied value. DEPTH=0 is a plain wire.
//   clk, rst_n  : clock, async active-low reset
//   rst_val_i   : value loaded into every stage while in reset
//   din_i       : input word
//   dout_o      : input word delayed by DEPTH clocks
// ---------------------------------------------------------------------------
module sync_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  if (DEPTH == 0) begin : g_bypass
    assign dout_o = din_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= rst_val_i;
      end else begin
        stage_q[0] <= din_i;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing for the display: free-running column/row counters, sync and
// blanking decode, a per-frame tick, and the final blanked pixel register.
// Optional feature macro: VGA_TEST_PATTERN_EN (colour bars on test_pattern).
//   clk    : pixel clock
//   rst_n  : asynchronous active-low reset
//   vga    : vga_timing_gen_if.master (counters out, rgb_in in, sync/rgb out)
// Sync/video_on appear PIPE_DELAY+1 clocks after the counter value that
// produced them; rgb is registered one clock after rgb_in.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISP_COLS  = DISP_COLS_DEF,
  parameter int unsigned DISP_ROWS  = DISP_ROWS_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter logic        SYNC_POL   = SYNC_POL_DEF,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = DISP_COLS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = DISP_ROWS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_COLS = CNT_W'(DISP_COLS);
  localparam logic [CNT_W-1:0] VIS_ROWS = CNT_W'(DISP_ROWS);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(DISP_COLS + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(DISP_COLS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(DISP_ROWS + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(DISP_ROWS + V_FP + V_SYNC - 1);

  // ---------------- raster counters ----------------
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == LAST_COL) begin
      col_d = '0;
      row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---------------- raw decode ----------------
  sync_bits_t raw;

  always_comb begin
    raw.vis = (col_q < VIS_COLS) && (row_q < VIS_ROWS);
    raw.hs  = ((col_q >= HS_START) && (col_q <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    raw.vs  = ((row_q >= VS_START) && (row_q <= VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  localparam sync_bits_t SYNC_RST = '{vis: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  // ---------------- delay line + pixel source ----------------
  sync_bits_t dly;
  logic [7:0] pix;

`ifdef VGA_TEST_PATTERN_EN
  // The bar index rides the same delay line as the sync flags so the bars
  // line up with the delayed visible area.
  localparam int unsigned DL_W = 6;

  logic [2:0]      bar_raw;
  logic [2:0]      bar_dly;
  logic [DL_W-1:0] dl_out;

  assign bar_raw = bar_index(col_q, DISP_COLS / NUM_BARS);

  sync_delay_line #(
    .DEPTH (PIPE_DELAY),
    .WIDTH (DL_W)
  ) u_sync_delay_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_val_i ({3'b000, SYNC_RST}),
    .din_i     ({bar_raw, raw}),
    .dout_o    (dl_out)
  );

  assign bar_dly = dl_out[5:3];
  assign dly     = dl_out[2:0];
  assign pix     = vga.test_pattern ? bar_color(bar_dly) : vga.rgb_in;
`else
  localparam int unsigned DL_W = 3;

  logic [DL_W-1:0] dl_out;

  sync_delay_line #(
    .DEPTH (PIPE_DELAY),
    .WIDTH (DL_W)
  ) u_sync_delay_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_val_i (SYNC_RST),
    .din_i     (raw),
    .dout_o    (dl_out)
  );

  assign dly = dl_out;
  assign pix = vga.rgb_in;
`endif

  // ---------------- output registers ----------------
  logic [7:0] rgb_q, rgb_d;
  logic       hs_q, vs_q, von_q, tick_q, tick_d;

  always_comb begin
    rgb_d  = dly.vis ? pix : '0;
    // Tick is taken straight from the counters, not through the delay line.
    tick_d = (col_q == '0) && (row_q == VIS_ROWS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      von_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      hs_q   <= dly.hs;
      vs_q   <= dly.vs;
      von_q  <= dly.vis;
      tick_q <= tick_d;
    end
  end

  assign vga.col_counter = col_q;
  assign vga.row_counter = row_q;
  assign vga.rgb         = rgb_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.video_on    = von_q;
  assign vga.frame_tick  = tick_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the raster scan for the 800x600 display: free-running column/row counters that drive the game-object draw stage, plus the sync, blanking and per-frame tick signals. It also consumes the 8-bit RGB from the draw stage and produces the final blanked, sync-aligned pixel to the DAC pins. It sits directly upstream (counters) and directly downstream (rgb) of the object-drawing logic. It is the only source of frame timing in the design.

## Interface
Parameters:
- DISP_COLS, 800, visible columns
- DISP_ROWS, 600, visible rows
- H_FP / H_SYNC / H_BP, 56 / 120 / 64, horizontal front porch / sync / back porch (pixels)
- V_FP / V_SYNC / V_BP, 37 / 6 / 23, vertical front porch / sync / back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync
- PIPE_DELAY, 1, draw-stage latency in clocks (0..4)

Ports:
- clk  in  1  pixel clock (50 MHz for 800x600@72)
- rst_n  in  1  asynchronous active-low reset
- col_counter  out  12  current column, 0..H_TOTAL-1
- row_counter  out  12  current row, 0..V_TOTAL-1
- rgb_in  in  8  pixel from draw stage, PIPE_DELAY clocks behind counters
- test_pattern  in  1  selects colour bars (only with macro)
- rgb  out  8  blanked pixel to DAC
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while rgb is in the visible area
- frame_tick  out  1  one-clock pulse at start of vertical blank

## Operation
- H_TOTAL = DISP_COLS+H_FP+H_SYNC+H_BP (1040); V_TOTAL = DISP_ROWS+V_FP+V_SYNC+V_BP (666).
- col_counter increments every clk; at H_TOTAL-1 wraps to 0 and row_counter increments; row at V_TOTAL-1 with col at H_TOTAL-1 wraps to 0. Both wrap in the same clock.
- Raw decode from counters (combinational):
  - vis = col<DISP_COLS && row<DISP_ROWS
  - hs = SYNC_POL when col in [DISP_COLS+H_FP, DISP_COLS+H_FP+H_SYNC-1] (856..975)
  - vs = SYNC_POL when row in [DISP_ROWS+V_FP, DISP_ROWS+V_FP+V_SYNC-1] (637..642)
- vis/hs/vs pass through a PIPE_DELAY-stage shift register, then one output register. Delay regs reset to vis=0, hs=vs=~SYNC_POL.
- rgb register: rgb <= vis_delayed ? rgb_in : 8'h00.
- frame_tick register: high for exactly one clock following counter value (col=0,row=DISP_ROWS). It is not delayed by PIPE_DELAY.
- Reset (any time, mid-line included): counters 0, rgb 0, video_on 0, frame_tick 0, hsync/vsync = ~SYNC_POL, all delay stages cleared. Scan restarts at (0,0) on the first clk after rst_n rises.

## Timing
- Counters: registered, update each rising clk edge, no stalls.
- hsync/vsync/video_on: PIPE_DELAY+1 clocks after the counter value that produced them.
- rgb: 1 clock after rgb_in. It is therefore aligned with sync when the draw stage latency equals PIPE_DELAY.
- PIPE_DELAY=0: no delay stages; outputs are 1 clock after counters.
- Line period 1040 clocks; hsync high 120 clocks; frame period 692,640 clocks; vsync high 6 lines (6240 clocks).
- frame_tick period equals the frame period exactly; first pulse after reset at clock 624,001.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - When test_pattern=1, rgb_in is replaced by eight vertical colour bars, each DISP_COLS/8 = 100 columns wide, with values 8'hFF, E0, FC, 1C, 1F, 03, E3, 00 left to right.
  - Bars are derived from the delayed column so they align with sync.
  - Blanking is still applied.
- Not defined: test_pattern is ignored, no bar logic is synthesised, and rgb is a function of rgb_in only.

## Structure
- Package vga_timing_pkg holds:
  - 800x600@72 timing constants (visible, porches, sync widths, totals)
  - SYNC_POL default
  - the colour-bar value list
- One sub-module, sync_delay_line: a parameterised-depth (0..4), width-3 shift register with asynchronous active-low reset value input. It carries vis/hs/vs (plus the column bar index when the macro is on).

## Test plan
- Reset release, run 2080 clocks -> col wraps 1039->0 at clocks 1040 and 2080, row 0->1->2; hsync first high 857+PIPE_DELAY clocks after reset release, for 120 clocks.
- Full frame with PIPE_DELAY=1 -> vsync high rows 637..642 (shifted 2 clocks), frame_tick exactly once per 692,640 clocks, row wraps 665->0.
- rgb_in held 8'hAB -> rgb=8'hAB only while video_on=1; count of non-zero rgb per frame = 480,000.
- Assert rst_n low at col=500,row=300 -> same/next edge all outputs at reset values; after release, counters restart at (0,0).
- PIPE_DELAY=0 and 3 builds -> video_on rises exactly 1 and 4 clocks after col_counter=0 on a visible row.
- With VGA_TEST_PATTERN_EN, test_pattern=1 -> rgb at delayed cols 0, 150, 799 = 8'hFF, 8'hE0, 8'h00; test_pattern=0 -> rgb follows rgb_in.
